// File: rtl/br_pht_ctrl.sv
// Pattern-history-table controller: table clear, prediction, update FIFO.
// Optional BR_PHT_BYPASS_EN forwards the in-flight write to the prediction.
module br_pht_ctrl #(
  parameter int unsigned DEPTH = 32,
  localparam int unsigned IW = $clog2(DEPTH)
) (
  input  logic          iClk,
  input  logic          iRst,
  input  logic          iFlush,
  input  logic [31:0]   iPredPc,
  output logic          oPredTaken,
  output logic          oPredValid,
  input  logic          iUpdValid,
  input  logic [31:0]   iUpdPc,
  input  logic          iUpdTaken,
  output logic          oUpdReady,
  output logic          oBusy,
  output logic [IW-1:0] oArrRIndex,
  output logic [IW-1:0] oArrWIndex,
  output logic [1:0]    oArrWIn,
  output logic          oArrWe,
  input  logic [1:0]    iArrROut,
  input  logic [1:0]    iArrWOut
);

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [IW-1:0] clr_q;
  logic [IW-1:0] clr_d;

  logic [1:0]    cnt_q;
  logic [IW-1:0] idx_q [2];
  logic          tkn_q [2];

  logic          push;
  logic          pop;
  logic          fifo_clr;
  logic [IW-1:0] upd_idx;
  logic [1:0]    nxt_ctr;

  function automatic logic [1:0] sat_step(
    input logic [1:0] c,
    input logic       t
  );
    if (t) return (c == 2'b11) ? c : c + 2'b01;
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  assign upd_idx    = iUpdPc[IW+1:2];
  assign oArrRIndex = iPredPc[IW+1:2];
  assign nxt_ctr    = sat_step(iArrWOut, tkn_q[0]);

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= CLEAR;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_d      = clr_q;
    push       = 1'b0;
    pop        = 1'b0;
    fifo_clr   = 1'b0;
    oArrWe     = 1'b0;
    oArrWIndex = '0;
    oArrWIn    = 2'b00;
    oBusy      = 1'b0;
    oPredValid = 1'b0;
    oUpdReady  = 1'b0;
    unique case (state_q)
      CLEAR: begin
        oBusy      = 1'b1;
        oArrWe     = 1'b1;
        oArrWIndex = clr_q;
        oArrWIn    = 2'b01;
        fifo_clr   = 1'b1;
        if (iFlush) begin
          clr_d = '0;
        end else if (clr_q == IW'(DEPTH - 1)) begin
          state_d = RUN;
          clr_d   = '0;
        end else begin
          clr_d = clr_q + 1'b1;
        end
      end
      RUN: begin
        oPredValid = 1'b1;
        oUpdReady  = (cnt_q < 2'd2);
        if (iFlush || iRst) begin
          state_d  = CLEAR;
          clr_d    = '0;
          fifo_clr = 1'b1;
        end else begin
          pop  = (cnt_q != 2'd0);
          push = iUpdValid && oUpdReady;
          if (pop) begin
            oArrWe     = 1'b1;
            oArrWIndex = idx_q[0];
            oArrWIn    = nxt_ctr;
          end
        end
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  // Entry 0 is always the head; a pop shifts entry 1 down.
  always_ff @(posedge iClk) begin
    if (iRst || fifo_clr) begin
      cnt_q <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b11: begin
          idx_q[0] <= upd_idx;
          tkn_q[0] <= iUpdTaken;
        end
        2'b10: begin
          idx_q[cnt_q[0]] <= upd_idx;
          tkn_q[cnt_q[0]] <= iUpdTaken;
          cnt_q           <= cnt_q + 2'd1;
        end
        2'b01: begin
          idx_q[0] <= idx_q[1];
          tkn_q[0] <= tkn_q[1];
          cnt_q    <= cnt_q - 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef BR_PHT_BYPASS_EN
  logic byp;
  assign byp = oArrWe && (state_q == RUN) && (oArrWIndex == oArrRIndex);
  assign oPredTaken = oPredValid && (byp ? oArrWIn[1] : iArrROut[1]);
`else
  assign oPredTaken = oPredValid && iArrROut[1];
`endif

endmodule

// File: doc/br_pht_ctrl.md
# br_pht_ctrl

Pattern-history-table controller for the branch predictor. It owns one 2-bit-wide DualPortArray instance. It sequences a full-table clear after reset or flush and answers fetch-stage predictions combinationally. It also buffers resolved-branch updates in a 2-entry FIFO and retires one per cycle as a saturating-counter read-modify-write through the array's write port.

## Interface
- DEPTH, 32, number of PHT entries; power of two, ≥ 2; IW = $clog2(DEPTH)
- Clock and reset: one clock; reset is synchronous and active-high.
- iClk  in  1  clock; all state updates on posedge
- iRst  in  1  synchronous active-high reset
- iFlush  in  1  single-cycle pulse; drop pending updates and re-clear table
- iPredPc  in  32  fetch PC; index = iPredPc[IW+1:2]
- oPredTaken  out  1  prediction (counter MSB); 0 while oPredValid=0
- oPredValid  out  1  table contents usable
- iUpdValid  in  1  update request
- iUpdPc  in  32  resolved-branch PC; index = iUpdPc[IW+1:2]
- iUpdTaken  in  1  resolved direction
- oUpdReady  out  1  update accepted this cycle when iUpdValid && oUpdReady
- oBusy  out  1  clear sequence in progress
- oArrRIndex  out  IW  to array read index; = iPredPc[IW+1:2]
- oArrWIndex  out  IW  to array write index
- oArrWIn  out  2  to array write data
- oArrWe  out  1  to array write enable
- iArrROut  in  2  from array read data (combinational on oArrRIndex)
- iArrWOut  in  2  from array current contents at oArrWIndex (combinational)

## Operation
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Counter update on taken: +1, saturating at 11.
- Counter update on not-taken: −1, saturating at 00.
- FSM states: CLEAR, RUN.
- CLEAR behaviour:
  - A clear index counter runs 0..DEPTH−1, one index per cycle.
  - oArrWe=1, oArrWIndex=counter, oArrWIn=01.
  - oBusy=1, oPredValid=0, oUpdReady=0.
  - The FIFO is held empty.
- CLEAR exit: after the write to index DEPTH−1 → RUN.
- RUN, FIFO non-empty:
  - Pop the head.
  - oArrWIndex = head index, oArrWIn = saturate(iArrWOut ± 1), oArrWe=1.
- RUN, FIFO empty: oArrWe=0, oArrWIndex=0, oArrWIn=00.
- RUN, FIFO capacity and readiness:
  - FIFO depth is 2, holding index and taken per entry.
  - oUpdReady = (count < 2).
  - When full, ready stays low even if a pop occurs in the same cycle.
- RUN, simultaneous push and pop at count=1: both occur; count stays 1; order is preserved.
- Back-to-back updates to the same index: each sees the previous write, because the array is written on the edge. No update is lost.
- iFlush in RUN: FIFO cleared, any pop that cycle is suppressed (oArrWe=0), clear index counter=0, → CLEAR.
- iFlush in CLEAR: clear index counter restarts at 0.
- iRst: highest priority; same effect as iFlush plus FSM forced to CLEAR.
- Reset values (the cycle after iRst is sampled high):
  - Flags: oBusy=1, oPredValid=0, oPredTaken=0, oUpdReady=0.
  - Array port: oArrWe=1, oArrWIndex=0, oArrWIn=01.
- Priority: iRst > iFlush > update pop > update push.

## Timing
- Prediction is combinational: iPredPc → oPredTaken in the same cycle.
- Clear duration is exactly DEPTH cycles; oBusy falls at the edge that writes index DEPTH−1.
- Update accepted at edge N into an empty FIFO:
  - Written at edge N+1.
  - Visible to prediction from cycle N+1→N+2 (base build).
- Sustained throughput: one update per cycle, with oUpdReady held high at count ≤ 1.
- Same-cycle read/write of one index returns the pre-write value unless bypass is enabled.

## Configuration
- BR_PHT_BYPASS_EN defined:
  - When oArrWe=1 in RUN and oArrRIndex==oArrWIndex, oPredTaken = oArrWIn[1].
  - Updates become visible one cycle earlier (from cycle N→N+1).
- BR_PHT_BYPASS_EN undefined: oPredTaken = iArrROut[1] always in RUN.
- Bypass is never applied during CLEAR, where the prediction is forced to 0.

## Test plan
- Reset then idle, DEPTH=32:
  - oBusy high exactly 32 cycles, writing indices 0..31 with 01.
  - Then oPredValid=1, and oPredTaken=0 for all indices.
- Four taken updates to PC 0x40 (index 16), back-to-back:
  - Counter sequence 10, 11, 11, 11.
  - oPredTaken=1 from the first write.
  - Three not-taken updates then leave counter 00.
- Hold iUpdValid=1 for 4 cycles while the bench forces a stall (FIFO full):
  - oUpdReady drops at count=2.
  - No accepted update is lost; array contents match a reference model.
- iFlush asserted with 2 updates pending:
  - No write of pending entries.
  - 32-cycle clear restarts; all counters end at 01.
- iRst asserted mid-clear at index 10: clear restarts from index 0; oBusy high a further 32 cycles.
- Same-index predict during an update write (01 → 10):
  - oPredTaken=0 without BR_PHT_BYPASS_EN.
  - oPredTaken=1 with BR_PHT_BYPASS_EN.
